// File: rtl/pc_sequencer_if.sv
// Fetch-stage bundle: PC register, instruction memory port and redirect sources.
// master = pc_sequencer side, slave = the environment.
// No storage; all handshake timing is owned by pc_sequencer.
interface pc_sequencer_if;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        fetch_valid;
    logic        flush;
    logic        hazard_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        fetch_error;

    modport master (
        input  pc_cur, imem_ack, hazard_stall,
        input  branch_taken, branch_target, jump_valid, jump_target,
        output pc_next, pc_stall, imem_req, imem_addr,
        output fetch_valid, flush, fetch_error
    );

    modport slave (
        output pc_cur, imem_ack, hazard_stall,
        output branch_taken, branch_target, jump_valid, jump_target,
        input  pc_next, pc_stall, imem_req, imem_addr,
        input  fetch_valid, flush, fetch_error
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch controller: steers PC register stall/pc_in, imem requests, IF/ID flush; PC_SEQ_TIMEOUT_EN adds a fetch watchdog.
// Latency: outputs combinational from state+inputs; redirect target fetched the cycle after the redirect.
// Backpressure: stalls the PC while imem_ack is low or hazard_stall holds; a request is never abandoned.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int          INSTR_BYTES    = 4,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic           clock,
    input  logic           reset_n,
    pc_sequencer_if.master bus
);
    localparam logic [31:0] INC = 32'(INSTR_BYTES);
    localparam logic [7:0]  TMO = 8'(TIMEOUT_CYCLES);

`ifdef PC_SEQ_TIMEOUT_EN
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, RETRY} state_t;
`else
    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
`endif

    state_t      state, state_nxt;
    logic        pend_v, pend_v_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic [7:0]  cnt, cnt_nxt;

    logic        redir_v, any_redir, consumed, err;
    logic [31:0] redir, seq_pc, tgt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= BOOT;
            pend_v  <= 1'b0;
            pend_pc <= 32'h0;
            cnt     <= 8'h0;
        end else begin
            state   <= state_nxt;
            pend_v  <= pend_v_nxt;
            pend_pc <= pend_pc_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        redir_v   = bus.branch_taken | bus.jump_valid;
        redir     = bus.branch_taken ? bus.branch_target : bus.jump_target;
        any_redir = redir_v | pend_v;
        seq_pc    = bus.pc_cur + INC;
        tgt       = redir_v ? redir : (pend_v ? pend_pc : seq_pc);

        state_nxt       = state;
        cnt_nxt         = cnt;
        consumed        = 1'b0;
        err             = 1'b0;
        bus.pc_stall    = 1'b1;
        bus.pc_next     = bus.pc_cur;
        bus.imem_req    = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.flush       = redir_v && (state != BOOT);

        case (state)
            BOOT: begin
                bus.pc_next = RESET_VECTOR;
                state_nxt   = FETCH;
            end
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    cnt_nxt = 8'h0;
                    if (any_redir) begin
                        // Returned instruction belongs to the killed path: drop it.
                        bus.pc_stall = 1'b0;
                        bus.pc_next  = tgt;
                        consumed     = 1'b1;
                    end else if (!bus.hazard_stall) begin
                        bus.fetch_valid = 1'b1;
                        bus.pc_stall    = 1'b0;
                        bus.pc_next     = seq_pc;
                    end else begin
                        bus.fetch_valid = 1'b1;
                        state_nxt       = HOLD;
                    end
                end else begin
`ifdef PC_SEQ_TIMEOUT_EN
                    if (cnt == TMO) begin
                        err       = 1'b1;
                        cnt_nxt   = 8'h0;
                        state_nxt = RETRY;
                    end else begin
                        cnt_nxt = cnt + 8'h1;
                    end
`else
                    // Saturate so an indefinite wait never wraps the counter.
                    if (cnt != TMO) cnt_nxt = cnt + 8'h1;
`endif
                end
            end
            HOLD: begin
                if (any_redir) begin
                    bus.pc_stall = 1'b0;
                    bus.pc_next  = tgt;
                    consumed     = 1'b1;
                    state_nxt    = FETCH;
                end else if (!bus.hazard_stall) begin
                    bus.pc_stall = 1'b0;
                    bus.pc_next  = seq_pc;
                    state_nxt    = FETCH;
                end
            end
`ifdef PC_SEQ_TIMEOUT_EN
            RETRY: state_nxt = FETCH;
`endif
            default: state_nxt = BOOT;
        endcase

        // Unconsumed redirects park here; the newest one wins.
        pend_v_nxt  = pend_v;
        pend_pc_nxt = pend_pc;
        if (consumed) begin
            pend_v_nxt = 1'b0;
        end else if (redir_v) begin
            pend_v_nxt  = 1'b1;
            pend_pc_nxt = redir;
        end
    end

    assign bus.imem_addr   = bus.pc_cur;
    assign bus.fetch_error = err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: PC register environment, cycle vector table through a scoreboard queue.
// Build with or without PC_SEQ_TIMEOUT_EN; the long no-ack sequence expects the matching behaviour.
module tb_pc_sequencer;
    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    pc_sequencer_if bus();

    pc_sequencer #(
        .RESET_VECTOR  (32'h0000_0000),
        .INSTR_BYTES   (4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // PC register in the environment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          bus.pc_cur <= 32'h0;
        else if (!bus.pc_stall) bus.pc_cur <= bus.pc_next;
    end

    typedef struct {
        logic        rst;
        logic        ack;
        logic        hz;
        logic        br;
        logic [31:0] bt;
        logic        jv;
        logic [31:0] jt;
        logic [31:0] addr;
        logic        req;
        logic        stall;
        logic        cnext;
        logic [31:0] nxt;
        logic        fv;
        logic        fl;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic rst, logic ack, logic hz, logic br, logic [31:0] bt,
                                logic jv, logic [31:0] jt, logic [31:0] addr, logic req,
                                logic stall, logic cnext, logic [31:0] nxt, logic fv,
                                logic fl, logic err);
        vec_t v;
        v.rst = rst; v.ack = ack; v.hz = hz; v.br = br; v.bt = bt; v.jv = jv; v.jt = jt;
        v.addr = addr; v.req = req; v.stall = stall; v.cnext = cnext; v.nxt = nxt;
        v.fv = fv; v.fl = fl; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, got, want);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        vec_t e;
        @(posedge clock);
        #1;
        reset_n           = v.rst;
        bus.imem_ack      = v.ack;
        bus.hazard_stall  = v.hz;
        bus.branch_taken  = v.br;
        bus.branch_target = v.bt;
        bus.jump_valid    = v.jv;
        bus.jump_target   = v.jt;
        exp_q.push_back(v);
        @(negedge clock);
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard vec %0d: got empty queue want entry", idx);
        end else begin
            e = exp_q.pop_front();
            chk("imem_addr", idx, bus.imem_addr, e.addr);
            chk("imem_req", idx, 32'(bus.imem_req), 32'(e.req));
            chk("pc_stall", idx, 32'(bus.pc_stall), 32'(e.stall));
            if (e.cnext) chk("pc_next", idx, bus.pc_next, e.nxt);
            chk("fetch_valid", idx, 32'(bus.fetch_valid), 32'(e.fv));
            chk("flush", idx, 32'(bus.flush), 32'(e.fl));
            chk("fetch_error", idx, 32'(bus.fetch_error), 32'(e.err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic req_e, err_e;
        reset_n = 1'b0;
        bus.imem_ack = 1'b0; bus.hazard_stall = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
        bus.jump_valid = 1'b0; bus.jump_target = 32'h0;

        //             rst ack hz br bt          jv jt          addr        req st cn next        fv fl er
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,     0, 32'h0,     32'h0,      0, 1, 1, 32'h0,     0, 0, 0)); // 0 reset
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h0,      0, 1, 1, 32'h0,     0, 0, 0)); // 1 boot
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h0,      1, 0, 1, 32'h4,     1, 0, 0)); // 2 first fetch
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h4,      1, 0, 1, 32'h8,     1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h8,      1, 0, 1, 32'hC,     1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'hC,      1, 0, 1, 32'h10,    1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h10,     1, 1, 0, 32'h0,     1, 0, 0)); // 6 hazard
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h10,     0, 1, 0, 32'h0,     0, 0, 0)); // HOLD
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h10,     0, 1, 0, 32'h0,     0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h10,     0, 0, 1, 32'h14,    0, 0, 0)); // release
        tbl.push_back(mk(1, 1, 0, 1, 32'h100,   1, 32'h200,   32'h14,     1, 0, 1, 32'h100,   0, 1, 0)); // 10 br+jmp
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h100,    1, 0, 1, 32'h104,   1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,     0, 32'h0,     32'h104,    1, 1, 0, 32'h0,     0, 0, 0)); // 12 wait
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,     1, 32'h40,    32'h104,    1, 1, 0, 32'h0,     0, 1, 0)); // jump mid-wait
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,     0, 32'h0,     32'h104,    1, 1, 0, 32'h0,     0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,     0, 32'h0,     32'h104,    1, 1, 0, 32'h0,     0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h104,    1, 0, 1, 32'h40,    0, 0, 0)); // 16 ack, discard
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h40,     1, 1, 0, 32'h0,     1, 0, 0)); // into HOLD
        tbl.push_back(mk(1, 0, 1, 1, 32'h80,    0, 32'h0,     32'h40,     0, 0, 1, 32'h80,    0, 1, 0)); // 18 redirect in HOLD
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h80,     1, 1, 0, 32'h0,     1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h80,     0, 0, 1, 32'h84,    0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h84,     1, 0, 1, 32'h88,    1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,     1, 32'h300,   32'h88,     1, 1, 0, 32'h0,     0, 1, 0)); // 22 pend 0x300
        tbl.push_back(mk(1, 0, 0, 1, 32'h400,   0, 32'h0,     32'h88,     1, 1, 0, 32'h0,     0, 1, 0)); // overwrite 0x400
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h88,     1, 0, 1, 32'h400,   0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h400,    1, 0, 1, 32'h404,   1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,     1, 32'h500,   32'h404,    1, 1, 0, 32'h0,     0, 1, 0)); // 26 pend 0x500
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,     0, 32'h0,     32'h0,      0, 1, 1, 32'h0,     0, 0, 0)); // reset mid-wait
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h0,      0, 1, 1, 32'h0,     0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h0,      1, 0, 1, 32'h4,     1, 0, 0)); // pending lost

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

        // Memory never acks at PC 0x4.
        for (int k = 0; k < 18; k++) begin
`ifdef PC_SEQ_TIMEOUT_EN
            req_e = ((k % 6) != 5);
            err_e = ((k % 6) == 4);
`else
            req_e = 1'b1;
            err_e = 1'b0;
`endif
            run(mk(1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h4, req_e, 1, 0, 32'h0, 0, 0, err_e), 100 + k);
        end
        run(mk(1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h4, 1, 0, 1, 32'h8, 1, 0, 0), 200);
        run(mk(1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h8, 1, 0, 1, 32'hC, 1, 0, 0), 201);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
